muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU issued from the decode/execute boundary and runs radix-2 shift-add multiplication or restoring division over 32 iterations.
- Services MTHI/MTLO writes and MFHI/MFLO reads.
- Raises stall_req toward the hazard logic whenever a HI/LO consumer or a new muldiv op arrives while busy.

Parameters:
- W, 32, operand width; HI/LO are W bits; iteration count equals W.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  issue a mul/div op this cycle (operands valid)
- op_div  in  1  1 = DIV/DIVU, 0 = MULT/MULTU
- op_unsigned  in  1  1 = unsigned variant
- src1  in  W  rs value (multiplicand / dividend)
- src2  in  W  rt value (multiplier / divisor)
- mthi  in  1  write HI from mt_data
- mtlo  in  1  write LO from mt_data
- mt_data  in  W  MTHI/MTLO data
- rd_hilo  in  1  MFHI/MFLO wants HI/LO this cycle
- flush  in  1  pipeline clear (exception/ERET); aborts the in-flight op
- busy  out  1  operation in progress
- stall_req  out  1  hold the requesting stage
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
- hi  out  W  HI register
- lo  out  W  LO register

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0; stall_req=0.
- States: IDLE, CALC, FIX.
- IDLE, start=1: latch operands at the edge and go to CALC with counter=W-1.
  - Signed ops latch |src1| and |src2|, plus neg_q = sign1^sign2 and neg_r = sign1.
  - Unsigned ops latch raw values with neg_q = neg_r = 0.
- CALC, one iteration per cycle:
  - MUL: shift-add into a 2W accumulator.
  - DIV: restoring step (shift remainder, trial subtract, set quotient bit).
  - At counter=0, go to FIX; otherwise decrement.
- FIX (one cycle): apply the sign negations. At the end-of-FIX edge:
  - MUL: hi = product[2W-1:W], lo = product[W-1:0].
  - DIV: lo = quotient, hi = remainder.
  - Go to IDLE with done=1 for exactly the next cycle.
- Latency: start sampled at edge E0; busy=1 for the W+1 cycles after E0; hi/lo valid and done=1 after edge E0+W+1 (33 for W=32).
- busy = (state != IDLE).
- stall_req = busy & (start | rd_hilo | mthi | mtlo), combinational. While stall_req=1, start/mthi/mtlo are ignored; the requester holds them.
- Divide by zero: iterations run normally. Result is forced to lo = all-ones and hi = src1 as latched (original signed value), regardless of signedness.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0, with no special casing.
- mthi/mtlo in IDLE with start=0: the register is written at the next edge; hi and lo may both be written in the same cycle.
- start and mthi/mtlo in the same IDLE cycle: start is accepted and the mt write is dropped.
- flush at any cycle: next state IDLE, busy=0, done=0. hi/lo are unchanged, including when flush coincides with the FIX edge. Any start or mt write that cycle is ignored.
- Reset mid-operation behaves as reset: hi/lo are cleared.
- hi/lo outputs are the registers themselves; no bypass from the in-flight result.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - MUL in CALC jumps to FIX as soon as the remaining unshifted multiplier bits are all zero. Minimum is 1 CALC cycle, e.g. src2=1 gives done 3 cycles after E0.
  - DIV with divisor zero skips CALC entirely (IDLE, then FIX, then the forced result).
  - done/busy semantics are otherwise identical.
- When undefined: fixed W CALC cycles for every op.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after start, busy high 33 cycles.
- MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via mthi/mtlo; start MULT; flush at CALC cycle 10 -> busy=0 next cycle, done never pulses, hi=0x11, lo=0x22; a new start the following cycle is accepted.
- During busy, assert rd_hilo, then mtlo (mt_data=0x5A) -> stall_req=1 each cycle until IDLE. Holding mtlo after done writes lo=0x5A one edge later.
- With MULDIV_EARLY_OUT_EN, MULTU 0x1234 * 1 -> lo=0x1234, done 3 edges after start; without it, done at 33.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide sequencer owning the HI/LO pair.
// Optional early termination is enabled by defining MULDIV_EARLY_OUT_EN.
module muldiv_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         op_div,
  input  logic         op_unsigned,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [W-1:0] mt_data,
  input  logic         rd_hilo,
  input  logic         flush,
  output logic         busy,
  output logic         stall_req,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;      // MUL: product; DIV: {remainder, quotient/dividend}
  logic [2*W-1:0] mc;       // MUL: shifted multiplicand; DIV: divisor in low half
  logic [W-1:0]   mr;
  logic [W-1:0]   src1_r;
  logic           is_div, neg_q, neg_r, dz;

  logic [W-1:0]   abs1, abs2;
  logic [W:0]     trial;
  logic [2*W-1:0] div_next, mul_next, mul_res;
  logic [W-1:0]   q_res, r_res;
  logic           calc_last;

  always_comb begin
    abs1     = (!op_unsigned && src1[W-1]) ? -src1 : src1;
    abs2     = (!op_unsigned && src2[W-1]) ? -src2 : src2;
    trial    = {acc[2*W-1:W], acc[W-1]} - {1'b0, mc[W-1:0]};
    div_next = trial[W] ? {acc[2*W-2:0], 1'b0}
                        : {trial[W-1:0], acc[W-2:0], 1'b1};
    mul_next = mr[0] ? acc + mc : acc;
    mul_res  = neg_q ? -acc : acc;
    q_res    = neg_q ? -acc[W-1:0] : acc[W-1:0];
    r_res    = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
`ifdef MULDIV_EARLY_OUT_EN
    // Remaining multiplier bits zero: the accumulator already holds the product.
    calc_last = (cnt == '0) || (!is_div && mr == '0);
`else
    calc_last = (cnt == '0);
`endif
  end

  assign busy      = (state != IDLE);
  assign stall_req = busy & (start | rd_hilo | mthi | mtlo);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      acc    <= '0;
      mc     <= '0;
      mr     <= '0;
      src1_r <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op_div;
            neg_q  <= !op_unsigned && (src1[W-1] ^ src2[W-1]);
            neg_r  <= !op_unsigned && src1[W-1];
            dz     <= op_div && (src2 == '0);
            src1_r <= src1;
            cnt    <= CW'(W - 1);
            mr     <= abs2;
            if (op_div) begin
              acc <= {{W{1'b0}}, abs1};
              mc  <= {{W{1'b0}}, abs2};
            end else begin
              acc <= '0;
              mc  <= {{W{1'b0}}, abs1};
            end
            state <= CALC;
`ifdef MULDIV_EARLY_OUT_EN
            if (op_div && (src2 == '0))
              state <= FIX;
`endif
          end else begin
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
          end
        end
        CALC: begin
          if (is_div) begin
            acc <= div_next;
          end else begin
            acc <= mul_next;
            mc  <= mc << 1;
            mr  <= mr >> 1;
          end
          if (calc_last)
            state <= FIX;
          else
            cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (dz) begin
            lo <= '1;
            hi <= src1_r;
          end else if (is_div) begin
            lo <= q_res;
            hi <= r_res;
          end else begin
            hi <= mul_res[2*W-1:W];
            lo <= mul_res[W-1:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a result scoreboard and latency checks.
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         resetn, start, op_div, op_unsigned, mthi, mtlo, rd_hilo, flush;
  logic [W-1:0] src1, src2, mt_data;
  logic         busy, stall_req, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_seq #(.W(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_div(op_div),
    .op_unsigned(op_unsigned), .src1(src1), .src2(src2), .mthi(mthi),
    .mtlo(mtlo), .mt_data(mt_data), .rd_hilo(rd_hilo), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int bitlen(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(W); i++)
      if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int lat_of(input logic d, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    int l;
    if (d) return (b == '0) ? 1 : int'(W) + 1;
    l = bitlen(b) + 2;
    return (l < int'(W) + 1) ? l : int'(W) + 1;
`else
    return int'(W) + 1;
`endif
  endfunction

  function automatic logic [63:0] model(input logic d, input logic u,
                                       input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] na, nb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    na = a;
    nb = b;
    if (!d) return u ? ({32'b0, a} * {32'b0, b}) : 64'(sa * sb);
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (u) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(na % nb), 32'(na / nb)};
  endfunction

  task automatic run_op(input string tag, input logic d, input logic u,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int edges, bn, lat;
    logic [2*W-1:0] e;
    lat = lat_of(d, b);
    exp_q.push_back({eh, el});
    op_div = d; op_unsigned = u; src1 = a; src2 = b; start = 1'b1;
    tick;
    start = 1'b0;
    edges = 0; bn = 0;
    while (!done && edges < 200) begin
      if (busy) bn++;
      tick;
      edges++;
    end
    chk({tag, "_latency"}, 64'(edges), 64'(lat));
    chk({tag, "_busy_cycles"}, 64'(bn), 64'(lat));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
    chk({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
    tick;
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic rd, ru;
    logic [63:0] m;

    resetn = 1'b0; start = 1'b0; op_div = 1'b0; op_unsigned = 1'b0;
    src1 = '0; src2 = '0; mthi = 1'b0; mtlo = 1'b0; mt_data = '0;
    rd_hilo = 1'b0; flush = 1'b0;
    tick; tick;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_stall", 64'(stall_req), 64'(0));
    resetn = 1'b1;
    rd_hilo = 1'b1;
    tick;
    chk("idle_rd_nostall", 64'(stall_req), 64'(0));
    rd_hilo = 1'b0;

    run_op("multu_max", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x7", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("div_m7d2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_dz", 1'b1, 1'b1, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_dz_neg", 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Preload, then abort a multiply mid-flight.
    mthi = 1'b1; mt_data = 32'h11;
    tick;
    mthi = 1'b0; mtlo = 1'b1; mt_data = 32'h22;
    tick;
    mtlo = 1'b0;
    chk("mt_hi", 64'(hi), 64'h11);
    chk("mt_lo", 64'(lo), 64'h22);
    op_div = 1'b0; op_unsigned = 1'b0; src1 = 32'd5; src2 = 32'h7FFF_FFFF; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    chk("pre_flush_busy", 64'(busy), 64'(1));
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_done", 64'(done), 64'(0));
    chk("flush_hi", 64'(hi), 64'h11);
    chk("flush_lo", 64'(lo), 64'h22);
    run_op("after_flush_early", 1'b0, 1'b1, 32'h1234, 32'd1, 32'h0, 32'h1234);

    // Stall behaviour; the mthi that accompanies start must be dropped.
    op_div = 1'b0; op_unsigned = 1'b1; src1 = 32'd2; src2 = 32'h4000_0000;
    start = 1'b1; mthi = 1'b1; mt_data = 32'hDEAD;
    tick;
    start = 1'b0; mthi = 1'b0;
    chk("start_drops_mthi", 64'(hi), 64'h0);
    rd_hilo = 1'b1;
    repeat (5) begin
      tick;
      chk("stall_rd", 64'(stall_req), 64'(1));
    end
    rd_hilo = 1'b0; mtlo = 1'b1; mt_data = 32'h5A;
    n = 0;
    tick;
    while (busy && n < 100) begin
      chk("stall_mtlo", 64'(stall_req), 64'(1));
      tick;
      n++;
    end
    chk("stall_end_busy", 64'(busy), 64'(0));
    chk("stall_end_done", 64'(done), 64'(1));
    chk("stall_end_nostall", 64'(stall_req), 64'(0));
    chk("stall_res_lo", 64'(lo), 64'h8000_0000);
    chk("stall_res_hi", 64'(hi), 64'h0);
    tick;
    mtlo = 1'b0;
    chk("held_mtlo", 64'(lo), 64'h5A);

    for (int i = 0; i < 6; i++) begin
      rd = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      m = model(rd, ru, ra, rb);
      run_op("rand", rd, ru, ra, rb, m[63:32], m[31:0]);
    end

    // Reset during an operation clears HI/LO.
    op_div = 1'b1; op_unsigned = 1'b1; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    chk("midrst_hi", 64'(hi), 64'h0);
    chk("midrst_lo", 64'(lo), 64'h0);
    chk("midrst_busy", 64'(busy), 64'(0));
    run_op("post_rst_divu", 1'b1, 1'b1, 32'd1000, 32'd3, 32'd1, 32'd333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
